// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the multi-port register file
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_NUM_WR = 2;

endpackage

// File: rtl/regfile_init_seq.sv
// rtl/regfile_init_seq.sv - post-reset sweep that preloads entry i with value i, then parks in RUN
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = $clog2(RF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data
);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_busy = 1'b0;
        init_we   = 1'b0;
        case (state_q)
            RF_INIT: begin
                init_busy = 1'b1;
                init_we   = 1'b1;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RF_RUN;
                end
            end
            default: begin
                state_d = RF_RUN;
            end
        endcase
    end

    assign init_addr = cnt_q;
    assign init_data = DATA_W'(cnt_q);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file: two clocked write ports, NUM_RD combinational reads
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        init_busy,
    output logic                        wr_rejected,
    input  logic [RF_NUM_WR-1:0]        we,
    input  logic [RF_NUM_WR*ADDR_W-1:0] waddr,
    input  logic [RF_NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD*ADDR_W-1:0]    raddr,
    output logic [NUM_RD*DATA_W-1:0]    rdata
);

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;

    regfile_init_seq #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [DATA_W-1:0]    mem_d [DEPTH];
    logic [ADDR_W-1:0]    wa    [RF_NUM_WR];
    logic [DATA_W-1:0]    wd    [RF_NUM_WR];
    logic [RF_NUM_WR-1:0] we_eff;
    logic [RF_NUM_WR-1:0] wr_en;
    logic                 wr_rejected_q, wr_rejected_d;

    // A write aimed at the hardwired zero entry is discarded outright, so it
    // never counts as rejected either.
    always_comb begin
        we_eff = '0;
        for (int p = 0; p < RF_NUM_WR; p++) begin
            wa[p]     = waddr[p*ADDR_W +: ADDR_W];
            wd[p]     = wdata[p*DATA_W +: DATA_W];
            we_eff[p] = we[p] && !((ZERO_REG != 0) && (wa[p] == '0));
        end
        wr_en         = init_busy ? '0 : we_eff;
        wr_rejected_d = init_busy && (|we_eff);
    end

    // Port 1 is applied last so it wins an address collision.
    always_comb begin
        mem_d = mem_q;
        if (init_we && !((ZERO_REG != 0) && (init_addr == '0))) begin
            mem_d[init_addr] = init_data;
        end
        for (int p = 0; p < RF_NUM_WR; p++) begin
            if (wr_en[p]) begin
                mem_d[wa[p]] = wd[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_rejected_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            wr_rejected_q <= wr_rejected_d;
        end
    end

    assign wr_rejected = wr_rejected_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        always_comb begin
            ra = raddr[k*ADDR_W +: ADDR_W];
            rd = mem_q[ra];
            if (BYPASS != 0) begin
                for (int p = 0; p < RF_NUM_WR; p++) begin
                    if (wr_en[p] && (wa[p] == ra)) begin
                        rd = wd[p];
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp with and without bypass
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  we = '0;
    logic [9:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata_b, rdata_n;
    logic        busy_b, busy_n, rej_b, rej_n;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    // dut_b: bypass + zero register; dut_n: no bypass, entry 0 is an ordinary register
    regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .init_busy(busy_b), .wr_rejected(rej_b),
        .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_b)
    );

    regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .init_busy(busy_n), .wr_rejected(rej_n),
        .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_n)
    );

    logic [31:0] m_b [32];
    logic [31:0] m_n [32];
    bit          m_run;
    int          m_cnt;
    bit          e_rej_b, e_rej_n;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_b[i] = '0;
            m_n[i] = '0;
        end
        m_run   = 0;
        m_cnt   = 0;
        e_rej_b = 0;
        e_rej_n = 0;
    endtask

    function automatic logic [31:0] exp_rd(bit is_b, int k);
        int a;
        a = int'(raddr[k*5 +: 5]);
        if (is_b) begin
            if (a == 0) return 32'h0;
            if (m_run && we[1] && int'(waddr[9:5]) == a) return wdata[63:32];
            if (m_run && we[0] && int'(waddr[4:0]) == a) return wdata[31:0];
            return m_b[a];
        end
        return m_n[a];
    endfunction

    // Advance the reference by one clock from the current inputs, then step the DUTs.
    task automatic tick();
        int a0, a1;
        a0 = int'(waddr[4:0]);
        a1 = int'(waddr[9:5]);
        if (!m_run) begin
            e_rej_b = (we[0] && a0 != 0) || (we[1] && a1 != 0);
            e_rej_n = |we;
            if (m_cnt != 0) m_b[m_cnt] = m_cnt;
            m_n[m_cnt] = m_cnt;
            m_cnt++;
            if (m_cnt == 32) m_run = 1;
        end else begin
            e_rej_b = 0;
            e_rej_n = 0;
            if (we[0]) begin
                if (a0 != 0) m_b[a0] = wdata[31:0];
                m_n[a0] = wdata[31:0];
            end
            if (we[1]) begin
                if (a1 != 0) m_b[a1] = wdata[63:32];
                m_n[a1] = wdata[63:32];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we    = '0;
        model_reset();
        #2;
        vec++;
        if (busy_b !== 1'b1 || busy_n !== 1'b1) begin
            errs++;
            $display("FAIL reset_busy: got %b/%b want 1/1", busy_b, busy_n);
        end
        vec++;
        if (rej_b !== 1'b0 || rej_n !== 1'b0) begin
            errs++;
            $display("FAIL reset_rej: got %b/%b want 0/0", rej_b, rej_n);
        end
        raddr = {5'd31, 5'd5};
        #1;
        vec++;
        if (rdata_b !== 64'h0 || rdata_n !== 64'h0) begin
            errs++;
            $display("FAIL reset_rdata: got %h/%h want 0", rdata_b, rdata_n);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_init_sweep(string name);
        int n;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        vec++;
        if (n != 32 || busy_n !== 1'b0) begin
            errs++;
            $display("FAIL %s_len: busy cycles %0d (busy_n=%b) want 32", name, n, busy_n);
        end
        raddr = {5'd31, 5'd5};
        #1;
        for (int k = 0; k < 2; k++) begin
            vec++;
            if (rdata_b[k*32 +: 32] !== exp_rd(1, k) || rdata_n[k*32 +: 32] !== exp_rd(0, k)) begin
                errs++;
                $display("FAIL %s_val%0d: got %h/%h want %h/%h", name, k,
                         rdata_b[k*32 +: 32], rdata_n[k*32 +: 32], exp_rd(1, k), exp_rd(0, k));
            end
        end
        raddr = '0;
        #1;
        vec++;
        if (rdata_b !== 64'h0) begin
            errs++;
            $display("FAIL %s_zero: got %h want 0", name, rdata_b);
        end
    endtask

    task automatic test_write_read();
        we    = 2'b01;
        waddr = {5'd0, 5'd7};
        wdata = {32'h0, 32'hDEAD_BEEF};
        raddr = {5'd0, 5'd7};
        #1;
        vec++;
        if (rdata_b[31:0] !== exp_rd(1, 0) || rdata_n[31:0] !== exp_rd(0, 0)) begin
            errs++;
            $display("FAIL wr_same_cycle: got %h/%h want %h/%h",
                     rdata_b[31:0], rdata_n[31:0], exp_rd(1, 0), exp_rd(0, 0));
        end
        tick();
        we = '0;
        #1;
        vec++;
        if (rdata_b[31:0] !== exp_rd(1, 0) || rdata_n[31:0] !== exp_rd(0, 0)) begin
            errs++;
            $display("FAIL wr_after_edge: got %h/%h want %h/%h",
                     rdata_b[31:0], rdata_n[31:0], exp_rd(1, 0), exp_rd(0, 0));
        end
    endtask

    task automatic test_collision();
        we    = 2'b11;
        waddr = {5'd9, 5'd9};
        wdata = {32'h2, 32'h1};
        raddr = {5'd9, 5'd9};
        #1;
        vec++;
        if (rdata_b !== {exp_rd(1, 1), exp_rd(1, 0)}) begin
            errs++;
            $display("FAIL coll_bypass: got %h want %h", rdata_b, {exp_rd(1, 1), exp_rd(1, 0)});
        end
        tick();
        we = '0;
        #1;
        vec++;
        if (rdata_b[31:0] !== exp_rd(1, 0) || rdata_n[31:0] !== exp_rd(0, 0)) begin
            errs++;
            $display("FAIL coll_stored: got %h/%h want %h/%h",
                     rdata_b[31:0], rdata_n[31:0], exp_rd(1, 0), exp_rd(0, 0));
        end
    endtask

    task automatic test_zero_reg();
        we    = 2'b01;
        waddr = '0;
        wdata = {32'h0, 32'hFFFF_FFFF};
        raddr = '0;
        #1;
        vec++;
        if (rdata_b[31:0] !== 32'h0) begin
            errs++;
            $display("FAIL zero_same_cycle: got %h want 0", rdata_b[31:0]);
        end
        tick();
        we = '0;
        #1;
        vec++;
        if (rdata_b[31:0] !== 32'h0 || rej_b !== 1'b0) begin
            errs++;
            $display("FAIL zero_after_edge: got %h rej %b want 0 rej 0", rdata_b[31:0], rej_b);
        end
        vec++;
        if (rdata_n[31:0] !== exp_rd(0, 0)) begin
            errs++;
            $display("FAIL zero_plain_entry: got %h want %h", rdata_n[31:0], exp_rd(0, 0));
        end
    endtask

    task automatic test_random(int iters);
        for (int i = 0; i < iters; i++) begin
            we    = 2'($urandom_range(0, 3));
            waddr = 10'($urandom);
            wdata = {$urandom, $urandom};
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 10'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                vec++;
                if (rdata_b[k*32 +: 32] !== exp_rd(1, k) || rdata_n[k*32 +: 32] !== exp_rd(0, k)) begin
                    errs++;
                    $display("FAIL rand_rd it%0d p%0d: got %h/%h want %h/%h", i, k,
                             rdata_b[k*32 +: 32], rdata_n[k*32 +: 32], exp_rd(1, k), exp_rd(0, k));
                end
            end
            tick();
            vec++;
            if (rej_b !== e_rej_b || rej_n !== e_rej_n || busy_b !== 1'b0) begin
                errs++;
                $display("FAIL rand_flags it%0d: rej %b/%b busy %b want %b/%b 0",
                         i, rej_b, rej_n, busy_b, e_rej_b, e_rej_n);
            end
        end
        we = '0;
    endtask

    task automatic test_init_reject();
        rst_n = 1'b0;
        we    = '0;
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        we    = 2'b01;
        waddr = {5'd0, 5'd3};
        wdata = {32'h0, 32'hAA};
        tick();
        we = '0;
        #1;
        vec++;
        if (rej_b !== e_rej_b || rej_n !== e_rej_n) begin
            errs++;
            $display("FAIL init_rej_pulse: got %b/%b want %b/%b", rej_b, rej_n, e_rej_b, e_rej_n);
        end
        tick();
        vec++;
        if (rej_b !== 1'b0 || rej_n !== 1'b0) begin
            errs++;
            $display("FAIL init_rej_width: got %b/%b want 0/0", rej_b, rej_n);
        end
        we    = 2'b01;
        waddr = '0;
        tick();
        we = '0;
        vec++;
        if (rej_b !== e_rej_b || rej_n !== e_rej_n) begin
            errs++;
            $display("FAIL init_rej_zero: got %b/%b want %b/%b", rej_b, rej_n, e_rej_b, e_rej_n);
        end
        for (int n = 0; n < 100 && !m_run; n++) tick();
        raddr = {5'd0, 5'd3};
        #1;
        vec++;
        if (rdata_b[31:0] !== exp_rd(1, 0) || rdata_n[31:0] !== exp_rd(0, 0) || busy_b !== 1'b0) begin
            errs++;
            $display("FAIL init_rej_entry: got %h/%h busy %b want %h/%h 0",
                     rdata_b[31:0], rdata_n[31:0], busy_b, exp_rd(1, 0), exp_rd(0, 0));
        end
    endtask

    task automatic test_reset_mid_init();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        rst_n = 1'b0;
        model_reset();
        raddr = {5'd8, 5'd5};
        #1;
        vec++;
        if (rdata_b !== 64'h0 || rdata_n !== 64'h0 || busy_b !== 1'b1) begin
            errs++;
            $display("FAIL mid_reset_clear: got %h/%h busy %b want 0/0 1", rdata_b, rdata_n, busy_b);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        test_init_sweep("mid_reinit");
    endtask

    initial begin
        test_reset();
        test_init_sweep("init");
        test_write_read();
        test_collision();
        test_zero_reg();
        test_random(300);
        test_init_reject();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
